unified_mem_arbiter: RTL and testbench

//  Shares one single-port 64-bit memory between the core's instruction fetch port and data port.

---
 rtl/unified_mem_arbiter_pkg.sv | 30 +++
 rtl/unified_mem_arbiter_if.sv | 48 ++++
 rtl/unified_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// FSM states, transaction owners and the latched memory request bundle.
package unified_mem_arbiter_pkg;

    localparam int unsigned ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } mem_owner_e;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } mem_req_t;

    function automatic logic [63:0] dword_addr(input logic [63:0] a);
        return a & ~64'h7;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and memory channels of the unified memory arbiter.
// slave = arbiter side, master = core and memory model side.
interface unified_mem_arbiter_if;

    logic        if_req;
    logic [63:0] if_addr;
    logic        if_kill;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port 64-bit memory between fetch and data ports.
// Data wins unless fetch has starved; fetch responses can be killed.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus,
    output logic                  busy
);

    localparam int unsigned CW =
        (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STARVE_LIMIT);

    arb_state_e  state_q;
    arb_state_e  state_d;
    mem_owner_e  owner_q;
    mem_req_t    req_q;
    logic [CW-1:0] starve_q;
    logic        kill_q;

    logic        starve_hit;
    logic        grant_d;
    logic        grant_if;
    logic        done;
    logic        kill_set;

    assign starve_hit = bus.if_req && (starve_q == CMAX);
    assign grant_d    = (state_q == ARB_IDLE) && bus.d_req && !starve_hit;
    assign grant_if   = (state_q == ARB_IDLE) && bus.if_req && !grant_d;
    assign done       = (state_q == ARB_RESP) && bus.mem_rvalid;

    // Kill sticks to the fetch from its grant cycle until the FSM idles.
    assign kill_set = bus.if_kill &&
                      (grant_if ||
                       ((owner_q == OWN_IF) && (state_q != ARB_IDLE)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_d || grant_if) begin
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (bus.mem_rvalid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.if_gnt    = grant_if;
        bus.d_gnt     = grant_d;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        if (state_q == ARB_REQ) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = req_q.we;
            bus.mem_addr  = dword_addr(req_q.addr);
            bus.mem_wdata = req_q.wdata;
            bus.mem_be    = req_q.be;
        end
        bus.if_rvalid = done && (owner_q == OWN_IF) &&
                        !kill_q && !bus.if_kill;
        bus.d_rvalid  = done && (owner_q == OWN_D);
        bus.if_rdata  = '0;
        if (bus.if_rvalid) begin
            bus.if_rdata = req_q.addr[2] ? bus.mem_rdata[63:32]
                                         : bus.mem_rdata[31:0];
        end
        bus.d_rdata = bus.d_rvalid ? bus.mem_rdata : '0;
        busy        = (state_q != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            req_q    <= '0;
            starve_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            if (grant_d) begin
                owner_q <= OWN_D;
                req_q   <= '{we:    bus.d_we,
                             addr:  bus.d_addr,
                             wdata: bus.d_wdata,
                             be:    bus.d_we ? bus.d_be : 8'hFF};
            end else if (grant_if) begin
                owner_q <= OWN_IF;
                req_q   <= '{we:    1'b0,
                             addr:  bus.if_addr,
                             wdata: 64'h0,
                             be:    8'hFF};
            end else if (done) begin
                owner_q <= OWN_NONE;
            end

            if (grant_d) begin
                if (!bus.if_req) begin
                    starve_q <= '0;
                end else if (starve_q != CMAX) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else if (grant_if) begin
                starve_q <= '0;
            end

            if (done) begin
                kill_q <= 1'b0;
            end else if (kill_set) begin
                kill_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level model.
// Memory model answers with random grant and response delays plus stray pulses.
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    unified_mem_arbiter_if bus();

    unified_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model of the arbiter at transaction level.
    bit          m_open, m_gdone, m_kill, m_sel;
    int          m_own;
    int          m_starve;
    logic        m_we;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_be;

    // Requester and memory model state.
    bit          if_pend, d_pend, awaiting;
    int          gwait, rwait;
    logic [63:0] mem_rd;

    function automatic logic [255:0] all_out();
        return {17'd0,
                bus.if_gnt, bus.if_rvalid, bus.if_rdata,
                bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.mem_req, bus.mem_we, bus.mem_addr,
                bus.mem_wdata, bus.mem_be, busy};
    endfunction

    task automatic model_clear();
        m_open = 0; m_gdone = 0; m_kill = 0; m_sel = 0;
        m_own = 0; m_starve = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        if_pend = 0; d_pend = 0; awaiting = 0;
        gwait = -1; rwait = -1;
    endtask

    task automatic drive(input int p_if, input int p_d);
        if (!if_pend) begin
            bus.if_addr = {$urandom, $urandom};
            if ($urandom_range(99) < p_if) begin
                if_pend = 1;
                bus.if_addr = {32'h0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            end
        end
        bus.if_req = if_pend;
        if (!d_pend) begin
            bus.d_we    = 1'($urandom);
            bus.d_addr  = {$urandom, $urandom};
            bus.d_wdata = {$urandom, $urandom};
            bus.d_be    = 8'($urandom);
            if ($urandom_range(99) < p_d) begin
                d_pend = 1;
                bus.d_addr = {32'h0, $urandom};
            end
        end
        bus.d_req = d_pend;

        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        mem_rd         = {$urandom, $urandom};
        bus.mem_rdata  = mem_rd;
        if (bus.mem_req) begin
            if (gwait < 0) gwait = $urandom_range(2);
            if (gwait == 0) bus.mem_gnt = 1'b1;
            else gwait--;
        end else if (awaiting) begin
            if (rwait > 0) rwait--;
            if (rwait == 0) bus.mem_rvalid = 1'b1;
        end else begin
            if ($urandom_range(99) < 5) bus.mem_rvalid = 1'b1;
            if ($urandom_range(99) < 5) bus.mem_gnt = 1'b1;
        end
        bus.if_kill = ($urandom_range(99) < 10) && !bus.mem_rvalid;
    endtask

    task automatic sample();
        bit e_ig, e_dg, e_req, e_rsp, e_irv, e_drv;
        e_ig = 0;
        e_dg = 0;
        if (!m_open) begin
            e_dg = bus.d_req && !(bus.if_req && m_starve == LIMIT);
            e_ig = bus.if_req && !e_dg;
        end
        e_req = m_open && !m_gdone;
        e_rsp = m_open && m_gdone && bus.mem_rvalid;
        e_irv = e_rsp && m_own == 1 && !m_kill;
        e_drv = e_rsp && m_own == 2;
        check("ctl",
              {bus.if_gnt, bus.d_gnt, busy, bus.mem_req,
               bus.if_rvalid, bus.d_rvalid},
              {e_ig, e_dg, m_open, e_req, e_irv, e_drv});
        if (e_req) begin
            check("mem", {bus.mem_we, bus.mem_addr, bus.mem_be},
                         {m_we, m_addr, m_be});
            if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (e_irv)
            check("if_rdata", bus.if_rdata,
                  m_sel ? mem_rd[63:32] : mem_rd[31:0]);
        if (e_drv && !m_we)
            check("d_rdata", bus.d_rdata, mem_rd);

        if (m_open && m_own == 1 && bus.if_kill) m_kill = 1;
        if (e_rsp) begin
            m_open = 0; m_gdone = 0; m_own = 0; m_kill = 0;
            awaiting = 0;
        end
        if (e_req && bus.mem_gnt) begin
            m_gdone  = 1;
            gwait    = -1;
            awaiting = 1;
            rwait    = $urandom_range(1, 3);
        end
        if (e_dg) begin
            m_open  = 1;
            m_own   = 2;
            m_we    = bus.d_we;
            m_addr  = {bus.d_addr[63:3], 3'b000};
            m_wdata = bus.d_wdata;
            m_be    = bus.d_we ? bus.d_be : 8'hFF;
            m_kill  = 0;
            if (!bus.if_req) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
        end
        if (e_ig) begin
            m_open   = 1;
            m_own    = 1;
            m_we     = 0;
            m_addr   = {bus.if_addr[63:3], 3'b000};
            m_be     = 8'hFF;
            m_sel    = bus.if_addr[2];
            m_kill   = bus.if_kill;
            m_starve = 0;
        end
        if (bus.if_gnt) if_pend = 0;
        if (bus.d_gnt) d_pend = 0;
    endtask

    task automatic step(input int p_if, input int p_d);
        @(posedge clk);
        #1;
        drive(p_if, p_d);
        @(negedge clk);
        sample();
    endtask

    initial begin
        int tries;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.if_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        mem_rd = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset", all_out(), '0);
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if (c < 1000) step(95, 95);
            else if (c < 2000) step(30, 60);
            else step(70, 20);
        end

        // Reset while waiting for the memory response.
        tries = 0;
        while (!(m_gdone && awaiting) && tries < 200) begin
            step(50, 50);
            tries++;
        end
        check("reach_resp", {31'd0, m_gdone && awaiting}, 1);
        @(posedge clk);
        #1;
        bus.if_req = 0; bus.d_req = 0; bus.if_kill = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0;
        rst = 1'b1;
        #1;
        check("rst_async", all_out(), '0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = {$urandom, $urandom};
        @(negedge clk);
        check("stray_rvalid", all_out(), '0);

        for (int c = 0; c < 400; c++) step(60, 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
